pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the Beta five-stage core. Sits beside the fetch and decode stages and sequences them:
- selects the next PC;
- selects the instruction register source for fetch and decode (`IR_SRC_*` from defines.v);
- inserts load-use bubbles;
- annuls the fetch slot on taken branches;
- injects exception instructions for illegal opcodes and external interrupts.

Decode reports opcode class and register numbers; pipe_ctrl returns stall and mux selects in the same cycle.

## Interface
Parameters:
- LD_BUBBLES, 2, bubbles inserted for a load-use hazard (1..3)
- EXC_HOLDOFF, 3, cycles after an injected exception during which interrupts are not accepted (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op_jmp, op_beq, op_bne  in  1 each  decode-stage opcode class
- zero  in  1  decode rd1 is zero
- dec_illop  in  1  decode holds an illegal opcode
- dec_ra1, dec_ra2  in  5 each  decode source registers
- dec_uses_ra2  in  1  decode reads ra2
- exec_is_load  in  1  execute stage holds LD or LDR
- exec_rc  in  5  execute stage destination
- pc_kernel  in  1  bit 31 of pc_decode (supervisor mode)
- mem_busy  in  1  memory not ready; freeze pipeline
- irq  in  1  asynchronous interrupt request, level
- stall  out  1  hold PC and decode IR
- freeze  out  1  hold all stages (mirrors mem_busy)
- ir_src_dec  out  2  decode-to-execute IR source
- ir_src_if  out  2  fetch-to-decode IR source
- pc_sel  out  3  0 PC+4, 1 branch_addr, 2 jump_addr, 3 ILLOP vector, 4 XADR vector, 5 reset vector
- exc_busy  out  1  holdoff window active

## Operation
Registered state: FSM, bubble counter `bub_cnt[1:0]`, holdoff counter `ho_cnt[2:0]`, and (with macro) a 2-flop irq synchronizer.

FSM states:
- RUN
- LDUSE: counting bubbles
- HOLD: exception holdoff

Each cycle applies the first matching rule:
1. **mem_busy**
   - freeze=1, stall=1; both ir_src = DATA; pc_sel=0.
   - No state or counter changes; exceptions are deferred.
2. **Exception** (RUN or HOLD only). Cause is dec_illop, or irq_sync && !pc_kernel && state!=HOLD.
   - ir_src_dec=EXCEPT, ir_src_if=NOP, stall=0.
   - pc_sel=3 for illop (illop wins over irq), otherwise 4.
   - Next state HOLD, ho_cnt=EXC_HOLDOFF-1.
3. **Load-use detect** (RUN or HOLD).
   - Condition: exec_is_load && exec_rc!=31 && (exec_rc==dec_ra1 || (dec_uses_ra2 && exec_rc==dec_ra2)).
   - stall=1, ir_src_dec=NOP, ir_src_if=DATA, pc_sel=0.
   - If LD_BUBBLES>1: enter LDUSE with bub_cnt=LD_BUBBLES-2. Otherwise stay.
4. **LDUSE**
   - Outputs as rule 3.
   - bub_cnt decrements; at 0, return to RUN (or to HOLD if ho_cnt!=0).
   - Branch and exception inputs are ignored while in LDUSE, because operands are invalid.
5. **Taken branch** (RUN or HOLD). Taken = op_jmp | (op_beq&zero) | (op_bne&!zero).
   - pc_sel = 2 for jmp, else 1; ir_src_if=NOP; ir_src_dec=DATA; stall=0.
6. **Default**: all DATA, pc_sel=0, stall=0.

Holdoff:
- In HOLD, ho_cnt decrements each non-frozen cycle, including cycles spent in LDUSE.
- At 0 the FSM returns to RUN.
- exc_busy = (state==HOLD).
- A dec_illop during HOLD is taken and reloads ho_cnt.

Register 31 never creates a hazard.

## Timing
- Outputs are combinational from registered state plus inputs, with zero-cycle latency. Inputs must be stable before the clk edge.
- A load-use hazard costs exactly LD_BUBBLES cycles of stall=1.
- A taken branch costs 1 annulled fetch slot.
- An exception costs 1 annulled fetch plus the injected instruction.
- irq latency is 2 clk from the synchronizer, plus any LDUSE or freeze cycles.
- While rst is asserted (async) and on the first cycle after deassertion, the state is RUN with counters 0.
- Output values while rst is asserted: stall=0, freeze=0, ir_src_dec=NOP, ir_src_if=NOP, pc_sel=5, exc_busy=0.
- Reset mid-LDUSE or mid-HOLD aborts immediately.

## Configuration
- `PIPE_CTRL_IRQ_EN` defined: irq synchronizer and interrupt path are compiled in.
- `PIPE_CTRL_IRQ_EN` undefined: irq is ignored and pc_sel never takes the value 4. HOLD is entered only on illop.

## Test plan
- **Load-use:** LD rc=5 in exec, decode reads ra1=5, LD_BUBBLES=2 -> stall=1 and ir_src_dec=NOP for exactly 2 cycles, then DATA.
- **No hazard on R31:** exec_rc=31 with dec_ra1=31 -> stall=0. Also dec_uses_ra2=0 with ra2 match -> stall=0.
- **Branches:** BEQ with zero=1 -> pc_sel=1, ir_src_if=NOP for 1 cycle. BNE with zero=1 -> pc_sel=0. JMP -> pc_sel=2.
- **Illegal opcode:** dec_illop=1 -> ir_src_dec=EXCEPT, pc_sel=3, then exc_busy=1 for 3 cycles. irq held high during those cycles -> not taken until exc_busy falls.
- **Freeze:** mem_busy=1 for 4 cycles during LDUSE -> freeze=stall=1, and bub_cnt holds. After release, the remaining bubble completes.
- **Reset and interrupt:** rst asserted mid-HOLD -> pc_sel=5 immediately. irq with pc_kernel=1 -> never taken. With pc_kernel=0 -> pc_sel=4 two cycles after irq rises.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode/execute status in, pipeline sequencing controls out.
// The slave modport is used by pipe_ctrl; the master modport is the
// datapath side that drives opcode/register information and consumes
// the stall and mux selects.
interface pipe_ctrl_if;
    // decode / execute status
    logic       op_jmp;
    logic       op_beq;
    logic       op_bne;
    logic       zero;
    logic       dec_illop;
    logic [4:0] dec_ra1;
    logic [4:0] dec_ra2;
    logic       dec_uses_ra2;
    logic       exec_is_load;
    logic [4:0] exec_rc;
    logic       pc_kernel;
    logic       mem_busy;
    logic       irq;
    // sequencing controls
    logic       stall;
    logic       freeze;
    logic [1:0] ir_src_dec;
    logic [1:0] ir_src_if;
    logic [2:0] pc_sel;
    logic       exc_busy;

    modport master (
        output op_jmp, op_beq, op_bne, zero, dec_illop, dec_ra1, dec_ra2,
               dec_uses_ra2, exec_is_load, exec_rc, pc_kernel, mem_busy, irq,
        input  stall, freeze, ir_src_dec, ir_src_if, pc_sel, exc_busy
    );

    modport slave (
        input  op_jmp, op_beq, op_bne, zero, dec_illop, dec_ra1, dec_ra2,
               dec_uses_ra2, exec_is_load, exec_rc, pc_kernel, mem_busy, irq,
        output stall, freeze, ir_src_dec, ir_src_if, pc_sel, exc_busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the Beta five-stage core.
// Chooses the next PC, the fetch/decode IR sources, inserts load-use
// bubbles, annuls the fetch slot on taken branches and injects exception
// instructions for illegal opcodes and (optionally) interrupts.
// IR source encodings mirror the core's IR_SRC_* values:
//   DATA = 0, NOP = 1, EXCEPT = 2.
// Build option: define PIPE_CTRL_IRQ_EN to compile in the irq synchronizer
// and the interrupt path; without it irq is ignored and pc_sel never
// selects the XADR vector.
// Outputs are decoded combinationally from the registered state because
// decode needs stall and mux selects within the same cycle.
module pipe_ctrl #(
    parameter int LD_BUBBLES  = 2,   // 1..3
    parameter int EXC_HOLDOFF = 3    // 1..7
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    localparam logic [2:0] PC_SEL_INC    = 3'd0;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
    localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
    localparam logic [2:0] PC_SEL_ILLOP  = 3'd3;
    localparam logic [2:0] PC_SEL_XADR   = 3'd4;
    localparam logic [2:0] PC_SEL_RESET  = 3'd5;

    // The first bubble is the detect cycle itself, so LDUSE counts the rest.
    localparam logic [1:0] BUB_INIT = (LD_BUBBLES > 1) ? 2'(LD_BUBBLES - 2) : 2'd0;
    localparam logic [2:0] HO_INIT  = 3'(EXC_HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_bub_cnt;
    logic [2:0] r_ho_cnt;

    logic       w_irq_sync;
    logic       w_hazard;
    logic       w_taken;
    logic       w_run_or_hold;
    logic       w_exc;
    logic       w_bubble;
    logic       w_branch;

    logic       w_stall;
    logic       w_freeze;
    logic [1:0] w_ir_src_dec;
    logic [1:0] w_ir_src_if;
    logic [2:0] w_pc_sel;

`ifdef PIPE_CTRL_IRQ_EN
    logic r_irq_q1;
    logic r_irq_q2;

    // Two-flop synchronizer for the asynchronous interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_q1 <= 1'b0;
            r_irq_q2 <= 1'b0;
        end else begin
            r_irq_q1 <= bus.irq;
            r_irq_q2 <= r_irq_q1;
        end
    end

    assign w_irq_sync = r_irq_q2;
`else
    logic w_unused_irq;
    assign w_unused_irq = bus.irq;
    assign w_irq_sync   = 1'b0;
`endif

    // R31 is hardwired zero, so writing it never creates a dependency.
    assign w_hazard = bus.exec_is_load && (bus.exec_rc != 5'd31) &&
                      ((bus.exec_rc == bus.dec_ra1) ||
                       (bus.dec_uses_ra2 && (bus.exec_rc == bus.dec_ra2)));

    assign w_taken = bus.op_jmp | (bus.op_beq & bus.zero) | (bus.op_bne & ~bus.zero);

    // Decode operands are invalid during LDUSE, so nothing else is honoured there.
    assign w_run_or_hold = (r_state != ST_LDUSE);

    // Interrupts are masked in supervisor mode and during the holdoff window.
    assign w_exc = w_run_or_hold &&
                   (bus.dec_illop || (w_irq_sync && !bus.pc_kernel && (r_state == ST_RUN)));

    assign w_bubble = (r_state == ST_LDUSE) || (w_run_or_hold && w_hazard);
    assign w_branch = w_run_or_hold && w_taken;

    // Sequencing decode: first matching rule wins
    always_comb begin
        w_stall      = 1'b0;
        w_freeze     = 1'b0;
        w_ir_src_dec = IR_SRC_DATA;
        w_ir_src_if  = IR_SRC_DATA;
        w_pc_sel     = PC_SEL_INC;
        if (rst) begin
            w_ir_src_dec = IR_SRC_NOP;
            w_ir_src_if  = IR_SRC_NOP;
            w_pc_sel     = PC_SEL_RESET;
        end else if (bus.mem_busy) begin
            w_stall  = 1'b1;
            w_freeze = 1'b1;
        end else if (w_exc) begin
            w_ir_src_dec = IR_SRC_EXCEPT;
            w_ir_src_if  = IR_SRC_NOP;
            w_pc_sel     = bus.dec_illop ? PC_SEL_ILLOP : PC_SEL_XADR;
        end else if (w_bubble) begin
            w_stall      = 1'b1;
            w_ir_src_dec = IR_SRC_NOP;
        end else if (w_branch) begin
            w_ir_src_if = IR_SRC_NOP;
            w_pc_sel    = bus.op_jmp ? PC_SEL_JUMP : PC_SEL_BRANCH;
        end else begin
            w_ir_src_dec = IR_SRC_DATA;
            w_ir_src_if  = IR_SRC_DATA;
            w_pc_sel     = PC_SEL_INC;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.freeze     = w_freeze;
    assign bus.ir_src_dec = w_ir_src_dec;
    assign bus.ir_src_if  = w_ir_src_if;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.exc_busy   = !rst && (r_state == ST_HOLD);

    // Controller FSM with bubble and holdoff counters; frozen while memory is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= 2'd0;
            r_ho_cnt  <= 3'd0;
        end else if (bus.mem_busy) begin
            r_state   <= r_state;
            r_bub_cnt <= r_bub_cnt;
            r_ho_cnt  <= r_ho_cnt;
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (w_exc) begin
                        r_state  <= ST_HOLD;
                        r_ho_cnt <= HO_INIT;
                    end else begin
                        if (w_hazard && (LD_BUBBLES > 1)) begin
                            r_state   <= ST_LDUSE;
                            r_bub_cnt <= BUB_INIT;
                        end else if ((r_state == ST_HOLD) && (r_ho_cnt == 3'd0)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= r_state;
                        end
                        // RUN always carries ho_cnt == 0, so this only counts in HOLD.
                        if (r_ho_cnt != 3'd0) begin
                            r_ho_cnt <= r_ho_cnt - 3'd1;
                        end else begin
                            r_ho_cnt <= r_ho_cnt;
                        end
                    end
                end
                ST_LDUSE: begin
                    // Holdoff keeps running while bubbles are inserted.
                    if (r_ho_cnt != 3'd0) begin
                        r_ho_cnt <= r_ho_cnt - 3'd1;
                    end else begin
                        r_ho_cnt <= r_ho_cnt;
                    end
                    if (r_bub_cnt == 2'd0) begin
                        r_state <= (r_ho_cnt != 3'd0) ? ST_HOLD : ST_RUN;
                    end else begin
                        r_bub_cnt <= r_bub_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_bub_cnt <= 2'd0;
                    r_ho_cnt  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
// (LD_BUBBLES=2, EXC_HOLDOFF=3). Interrupt scenarios adapt to whether
// PIPE_CTRL_IRQ_EN is defined for the build.
module tb_pipe_ctrl;

    localparam logic [1:0] DATA = 2'd0;
    localparam logic [1:0] NOP  = 2'd1;
    localparam logic [1:0] EXC  = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    int         n_run  = 0;
    int         n_fail = 0;
    logic [9:0] obs;
    logic [9:0] exp_v;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.LD_BUBBLES(2), .EXC_HOLDOFF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {stall, freeze, ir_src_dec, ir_src_if, pc_sel, exc_busy}
    assign obs = {bus.stall, bus.freeze, bus.ir_src_dec, bus.ir_src_if, bus.pc_sel, bus.exc_busy};

    function automatic logic [9:0] ev(input logic s, input logic f, input logic [1:0] d,
                                      input logic [1:0] i, input logic [2:0] p, input logic b);
        return {s, f, d, i, p, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        bus.op_jmp = 1'b0; bus.op_beq = 1'b0; bus.op_bne = 1'b0; bus.zero = 1'b0;
        bus.dec_illop = 1'b0; bus.dec_ra1 = 5'd1; bus.dec_ra2 = 5'd2;
        bus.dec_uses_ra2 = 1'b0; bus.exec_is_load = 1'b0; bus.exec_rc = 5'd0;
        bus.pc_kernel = 1'b0; bus.mem_busy = 1'b0; bus.irq = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        bus.dec_illop = 1'b1; bus.mem_busy = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, NOP, NOP, 3'd5, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_vals: got %b want %b", obs, exp_v); end
        tick();
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_held: got %b want %b", obs, exp_v); end
        clear_inputs();
        rst = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_release: got %b want %b", obs, exp_v); end
        tick();
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL first_run: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_load_use;
        clear_inputs();
        bus.exec_is_load = 1'b1; bus.exec_rc = 5'd5; bus.dec_ra1 = 5'd5; bus.dec_ra2 = 5'd9;
        #1; exp_v = ev(1'b1, 1'b0, NOP, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_bub1: got %b want %b", obs, exp_v); end
        tick();
        bus.exec_is_load = 1'b0; bus.op_jmp = 1'b1;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_bub2_ignores_jmp: got %b want %b", obs, exp_v); end
        tick();
        bus.op_jmp = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_done: got %b want %b", obs, exp_v); end
        bus.exec_is_load = 1'b1; bus.exec_rc = 5'd5; bus.dec_ra1 = 5'd3;
        bus.dec_ra2 = 5'd5; bus.dec_uses_ra2 = 1'b1;
        #1; exp_v = ev(1'b1, 1'b0, NOP, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_ra2: got %b want %b", obs, exp_v); end
        tick();
        clear_inputs();
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_ra2_bub2: got %b want %b", obs, exp_v); end
        tick();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ld_ra2_done: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_no_r31;
        clear_inputs();
        exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0);
        bus.exec_is_load = 1'b1; bus.exec_rc = 5'd31; bus.dec_ra1 = 5'd31;
        bus.dec_ra2 = 5'd31; bus.dec_uses_ra2 = 1'b1;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL r31_no_hazard: got %b want %b", obs, exp_v); end
        bus.exec_rc = 5'd5; bus.dec_ra1 = 5'd7; bus.dec_ra2 = 5'd5; bus.dec_uses_ra2 = 1'b0;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ra2_unused: got %b want %b", obs, exp_v); end
        bus.exec_is_load = 1'b0; bus.dec_ra1 = 5'd5;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL not_load: got %b want %b", obs, exp_v); end
        tick();
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL no_stall_state: got %b want %b", obs, exp_v); end
        clear_inputs();
    endtask

    task automatic test_branches;
        clear_inputs();
        bus.op_beq = 1'b1; bus.zero = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, DATA, NOP, 3'd1, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL beq_taken: got %b want %b", obs, exp_v); end
        tick();
        clear_inputs();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL beq_one_slot: got %b want %b", obs, exp_v); end
        bus.op_bne = 1'b1; bus.zero = 1'b1;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bne_not_taken: got %b want %b", obs, exp_v); end
        bus.zero = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, NOP, 3'd1, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bne_taken: got %b want %b", obs, exp_v); end
        tick();
        clear_inputs();
        bus.op_jmp = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, DATA, NOP, 3'd2, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL jmp: got %b want %b", obs, exp_v); end
        bus.op_jmp = 1'b0; bus.op_beq = 1'b1; bus.zero = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL beq_not_taken: got %b want %b", obs, exp_v); end
        tick();
        clear_inputs();
    endtask

    task automatic test_illop;
        clear_inputs();
        bus.dec_illop = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, EXC, NOP, 3'd3, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL illop: got %b want %b", obs, exp_v); end
        tick();
        bus.dec_illop = 1'b0; bus.irq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b1); n_run++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL holdoff[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
`ifdef PIPE_CTRL_IRQ_EN
        #1; exp_v = ev(1'b0, 1'b0, EXC, NOP, 3'd4, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_after_holdoff: got %b want %b", obs, exp_v); end
        bus.irq = 1'b0;
        repeat (4) tick();
`else
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_ignored: got %b want %b", obs, exp_v); end
        bus.irq = 1'b0;
        tick();
`endif
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL holdoff_end: got %b want %b", obs, exp_v); end
        // illop inside the holdoff window reloads it
        bus.dec_illop = 1'b1;
        tick();
        bus.dec_illop = 1'b0;
        tick();
        bus.dec_illop = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, EXC, NOP, 3'd3, 1'b1); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL illop_in_hold: got %b want %b", obs, exp_v); end
        tick();
        bus.dec_illop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b1); n_run++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL reload[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reload_end: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_freeze;
        clear_inputs();
        bus.exec_is_load = 1'b1; bus.exec_rc = 5'd5; bus.dec_ra1 = 5'd5;
        #1; exp_v = ev(1'b1, 1'b0, NOP, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL frz_bub1: got %b want %b", obs, exp_v); end
        tick();
        bus.exec_is_load = 1'b0; bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; exp_v = ev(1'b1, 1'b1, DATA, DATA, 3'd0, 1'b0); n_run++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL frozen[%0d]: got %b want %b", i, obs, exp_v); end
            tick();
        end
        bus.mem_busy = 1'b0;
        #1; exp_v = ev(1'b1, 1'b0, NOP, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL frz_bub2: got %b want %b", obs, exp_v); end
        tick();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL frz_done: got %b want %b", obs, exp_v); end
        bus.mem_busy = 1'b1; bus.dec_illop = 1'b1;
        #1; exp_v = ev(1'b1, 1'b1, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL busy_defers_illop: got %b want %b", obs, exp_v); end
        tick();
        clear_inputs();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL illop_not_taken_frozen: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_reset_mid;
        clear_inputs();
        bus.dec_illop = 1'b1;
        tick();
        clear_inputs();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b1); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL hold_before_rst: got %b want %b", obs, exp_v); end
        rst = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, NOP, NOP, 3'd5, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_hold: got %b want %b", obs, exp_v); end
        rst = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL after_rst_hold: got %b want %b", obs, exp_v); end
        tick();
        bus.exec_is_load = 1'b1; bus.exec_rc = 5'd5; bus.dec_ra1 = 5'd5;
        tick();
        clear_inputs();
        rst = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, NOP, NOP, 3'd5, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_lduse: got %b want %b", obs, exp_v); end
        rst = 1'b0;
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL after_rst_lduse: got %b want %b", obs, exp_v); end
        tick();
    endtask

    task automatic test_irq;
        clear_inputs();
        exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0);
`ifdef PIPE_CTRL_IRQ_EN
        bus.pc_kernel = 1'b1; bus.irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1; n_run++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL kernel_irq[%0d]: got %b want %b", i, obs, exp_v); end
        end
        bus.pc_kernel = 1'b0; bus.irq = 1'b0;
        repeat (3) tick();
        bus.irq = 1'b1;
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_c0: got %b want %b", obs, exp_v); end
        tick();
        #1; n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_c1: got %b want %b", obs, exp_v); end
        tick();
        #1; exp_v = ev(1'b0, 1'b0, EXC, NOP, 3'd4, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_c2: got %b want %b", obs, exp_v); end
        bus.irq = 1'b0;
        repeat (4) tick();
        bus.irq = 1'b1;
        repeat (2) tick();
        bus.dec_illop = 1'b1;
        #1; exp_v = ev(1'b0, 1'b0, EXC, NOP, 3'd3, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL illop_over_irq: got %b want %b", obs, exp_v); end
        clear_inputs();
        repeat (4) tick();
        #1; exp_v = ev(1'b0, 1'b0, DATA, DATA, 3'd0, 1'b0); n_run++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL irq_idle: got %b want %b", obs, exp_v); end
`else
        bus.irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1; n_run++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL irq_disabled[%0d]: got %b want %b", i, obs, exp_v); end
        end
        clear_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_r31();
        test_branches();
        test_illop();
        test_freeze();
        test_reset_mid();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
